// File: rtl/mod_goldilocks_reduce_pipe_if.sv
// Valid/ready stream bundle for the Goldilocks reduction pipeline.
// The master modport drives operands and out_ready; the slave modport is the reducer.
interface mod_goldilocks_reduce_pipe_if #(
  parameter int unsigned P_WIDTH   = 64,
  parameter int unsigned D_WIDTH   = 128,
  parameter int unsigned TAG_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 mode_in;
  logic [D_WIDTH-1:0]   A_in;
  logic [TAG_WIDTH-1:0] tag_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [P_WIDTH-1:0]   R_out;
  logic [TAG_WIDTH-1:0] tag_out;
  logic                 busy;

  modport master (
    output in_valid, mode_in, A_in, tag_in, out_ready,
    input  in_ready, out_valid, R_out, tag_out, busy
  );

  modport slave (
    input  in_valid, mode_in, A_in, tag_in, out_ready,
    output in_ready, out_valid, R_out, tag_out, busy
  );
endinterface

// File: rtl/mod_goldilocks_reduce_pipe.sv
// Three-stage reduction of a 96/128-bit value modulo p = 2^64 - 2^32 + 1.
// Uses 2^96 == -1 and 2^64 == 2^32 - 1 (mod p); the output is always canonical.
module mod_goldilocks_reduce_pipe #(
  parameter int unsigned P_WIDTH   = 64,
  parameter int unsigned SEG_WIDTH = 32,
  parameter int unsigned D_WIDTH   = 128,
  parameter int unsigned TAG_WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  mod_goldilocks_reduce_pipe_if.slave bus
);

  localparam logic [P_WIDTH-1:0] P   = {{SEG_WIDTH{1'b1}}, {(SEG_WIDTH-1){1'b0}}, 1'b1};
  // 2^64 mod p, folded back in when the stage-2 sum carries out
  localparam logic [P_WIDTH-1:0] EPS = {{SEG_WIDTH{1'b0}}, {SEG_WIDTH{1'b1}}};

  logic                 en;
  logic                 v1_q, v2_q, v3_q;
  logic [P_WIDTH-1:0]   r1_q, r2_q, r3_q;
  logic [SEG_WIDTH-1:0] d_q;
  logic [TAG_WIDTH-1:0] tag1_q, tag2_q, tag3_q;

  logic [P_WIDTH-1:0]   x;
  logic [SEG_WIDTH-1:0] c;
  logic [P_WIDTH:0]     t;
  logic [P_WIDTH-1:0]   r1_d;
  logic [P_WIDTH-1:0]   m;
  logic [P_WIDTH:0]     s;
  logic [P_WIDTH-1:0]   r2_d;
  logic [P_WIDTH-1:0]   r3_d;

  // Whole pipe advances together; stalls only when the output slot is full and blocked.
  assign en = ~v3_q | bus.out_ready;

  // Stage 1: fold the 2^96 segment in as a subtraction, correcting a borrow by adding p.
  always_comb begin
    x    = bus.A_in[P_WIDTH-1:0];
    c    = bus.mode_in ? bus.A_in[D_WIDTH-1 -: SEG_WIDTH] : '0;
    t    = {1'b0, x} - {{(P_WIDTH+1-SEG_WIDTH){1'b0}}, c};
    r1_d = t[P_WIDTH] ? (t[P_WIDTH-1:0] + P) : t[P_WIDTH-1:0];
  end

  // Stage 2: add d*(2^32-1); a carry out is worth 2^64 == 2^32-1 and cannot overflow again.
  always_comb begin
    m    = {d_q, {SEG_WIDTH{1'b0}}} + ~{{SEG_WIDTH{1'b0}}, d_q} + P_WIDTH'(1);
    s    = {1'b0, r1_q} + {1'b0, m};
    r2_d = s[P_WIDTH] ? (s[P_WIDTH-1:0] + EPS) : s[P_WIDTH-1:0];
  end

  // Stage 3: r2 < 2p, so one conditional subtract makes it canonical.
  always_comb begin
    r3_d = (r2_q >= P) ? (r2_q - P) : r2_q;
  end

  // Pipeline registers; output data only updates for valid transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      r1_q   <= '0;
      r2_q   <= '0;
      r3_q   <= '0;
      d_q    <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
    end else if (en) begin
      v1_q   <= bus.in_valid;
      r1_q   <= r1_d;
      d_q    <= bus.A_in[P_WIDTH+SEG_WIDTH-1:P_WIDTH];
      tag1_q <= bus.tag_in;
      v2_q   <= v1_q;
      r2_q   <= r2_d;
      tag2_q <= tag1_q;
      v3_q   <= v2_q;
      if (v2_q) begin
        r3_q   <= r3_d;
        tag3_q <= tag2_q;
      end
    end
  end

  // in_ready is held high during reset; the reset branch above ignores any input.
  assign bus.in_ready  = en | rst;
  assign bus.out_valid = v3_q;
  assign bus.R_out     = r3_q;
  assign bus.tag_out   = tag3_q;
  assign bus.busy      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_mod_goldilocks_reduce_pipe.sv
// Directed bench for the Goldilocks reduction pipeline.
module tb_mod_goldilocks_reduce_pipe;

  localparam logic [127:0] P128 = 128'hFFFFFFFF00000001;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [63:0] got_r[$];
  logic [7:0]  got_t[$];

  mod_goldilocks_reduce_pipe_if #(.P_WIDTH(64), .D_WIDTH(128), .TAG_WIDTH(8)) bus ();

  mod_goldilocks_reduce_pipe #(
    .P_WIDTH(64), .SEG_WIDTH(32), .D_WIDTH(128), .TAG_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output handshake in arrival order.
  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      got_r.push_back(bus.R_out);
      got_t.push_back(bus.tag_out);
    end
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One isolated transaction with out_ready high; checks exact 3-cycle latency and 1-cycle pulse.
  task automatic single(input string name, input logic mode, input logic [127:0] a,
                        input logic [7:0] tag, input logic [63:0] exp);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode_in  = mode;
    bus.A_in     = a;
    bus.tag_in   = tag;
    #1;
    chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({name, "_valid_c1"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk({name, "_valid_c2"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk({name, "_valid_c3"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_r"}, bus.R_out, exp);
    chk({name, "_tag"}, 64'(bus.tag_out), 64'(tag));
    @(negedge clk);
    chk({name, "_valid_c4"}, 64'(bus.out_valid), 64'd0);
  endtask

  logic [127:0] sa[8];
  logic         sm[8];
  logic [63:0]  sexp[8];
  logic [127:0] a_eff;
  int           sent;
  logic         acc;

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mode_in   = 1'b0;
    bus.A_in      = '0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_r_out", bus.R_out, 64'd0);
    chk("rst_tag_out", 64'(bus.tag_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;

    // Directed vectors
    single("zero", 1'b0, 128'h0, 8'h11, 64'h0);
    single("eq_p", 1'b0, 128'hFFFFFFFF00000001, 8'h22, 64'h0);
    single("p_plus5", 1'b0, 128'hFFFFFFFF00000006, 8'h23, 64'h5);
    single("ones96", 1'b0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 8'h33, 64'hFFFFFFFEFFFFFFFF);
    single("c1_mode1", 1'b1, 128'h1 << 96, 8'h44, 64'hFFFFFFFF00000000);
    single("c1_mode0", 1'b0, 128'h1 << 96, 8'h45, 64'h0);
    single("cmax_x0", 1'b1, 128'hFFFFFFFF_00000000_00000000_00000000, 8'h46,
           64'hFFFFFFFE00000002);
    single("x_max", 1'b0, 128'hFFFFFFFF_FFFFFFFF, 8'h47, 64'h00000000FFFFFFFE);

    // Stream of 8 random ops with a 4-cycle output stall
    for (int i = 0; i < 8; i++) begin
      sa[i]   = {$urandom, $urandom, $urandom, $urandom};
      sm[i]   = 1'($urandom_range(0, 1));
      a_eff   = sm[i] ? sa[i] : {32'h0, sa[i][95:0]};
      sexp[i] = 64'(a_eff % P128);
    end
    got_r.delete();
    got_t.delete();
    sent = 0;
    acc  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (acc) sent++;
      if (sent == 8 && got_r.size() == 8) break;
      bus.out_ready = !(k >= 4 && k <= 7);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.mode_in = sm[sent];
        bus.A_in    = sa[sent];
        bus.tag_in  = 8'(sent);
      end
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (k >= 4 && k <= 7) chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", 64'(got_r.size()), 64'd8);
    for (int i = 0; i < 8 && i < got_r.size(); i++) begin
      chk("stream_tag", 64'(got_t[i]), 64'(i));
      chk("stream_r", got_r[i], sexp[i]);
    end

    // Reset with three transactions in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.mode_in  = 1'b0;
      bus.A_in     = 128'(i + 1);
      bus.tag_in   = 8'(8'h60 + i);
      @(negedge clk);
    end
    chk("flight_busy", 64'(bus.busy), 64'd1);
    chk("flight_valid", 64'(bus.out_valid), 64'd1);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.A_in     = 128'h1234;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("postrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("postrst_busy", 64'(bus.busy), 64'd0);
    bus.out_ready = 1'b1;
    single("after_rst", 1'b0, 128'hFFFFFFFF00000006, 8'hA5, 64'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
